s3g_packet_sender: RTL and testbench



---
 rtl/s3g_packet_sender_pkg.sv | 26 ++
 rtl/s3g_packet_sender_crc8.sv | 34 +++
 rtl/s3g_packet_sender.sv | 199 +++++++++++++++++++
 tb/tb_s3g_packet_sender.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_packet_sender_pkg.sv
// Shared constants for the S3G packet sender: frame header, CRC8 polynomial,
// FSM state encodings and the byte-wise CRC8 update.
package s3g_packet_sender_pkg;

    localparam logic [7:0] S3G_HEADER = 8'hD5;
    localparam logic [7:0] CRC8_POLY  = 8'h8C;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_HDR = 3'd1;
    localparam logic [2:0] ST_SEND_LEN = 3'd2;
    localparam logic [2:0] ST_SEND_PAY = 3'd3;
    localparam logic [2:0] ST_SEND_CRC = 3'd4;
    localparam logic [2:0] ST_WAIT_TX  = 3'd5;
    localparam logic [2:0] ST_GAP      = 3'd6;

    // Maxim/iButton CRC8, reflected, one full byte per call.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC8_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_packet_sender_crc8.sv
// Byte-serial CRC8 accumulator with synchronous clear and enable.
module s3g_packet_sender_crc8
    import s3g_packet_sender_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_update(crc_q, data_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/s3g_packet_sender.sv
// S3G framer: buffers a payload, then sends header, length, payload and CRC8
// one byte at a time over a tx_wr/tx_done UART handshake.
module s3g_packet_sender
    import s3g_packet_sender_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter logic [7:0]  HEADER      = S3G_HEADER,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       wr_full,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] count,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done
);

    localparam logic [7:0]  MaxCnt  = 8'(MAX_PAYLOAD);
    localparam logic [15:0] GapLast = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  sent_q, sent_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wr_q, tx_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0] pay_mem_q [MAX_PAYLOAD];
    logic       mem_we;
    logic [7:0] pay_rd;
    logic       crc_clr, crc_en;
    logic [7:0] crc;
    logic [2:0] nxt_send;
    logic [7:0] nxt_byte;

    assign pay_rd = pay_mem_q[idx_q[ADDR_W-1:0]];

    s3g_packet_sender_crc8 u_crc8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (tx_data_q),
        .crc_o  (crc)
    );

    // Which byte follows the one last issued, and its value.
    always_comb begin
        case (sent_q)
            ST_SEND_HDR: nxt_send = ST_SEND_LEN;
            ST_SEND_LEN: nxt_send = (len_q == 8'd0) ? ST_SEND_CRC : ST_SEND_PAY;
            ST_SEND_PAY: nxt_send = (idx_q == len_q) ? ST_SEND_CRC : ST_SEND_PAY;
            default:     nxt_send = ST_SEND_CRC;
        endcase
        case (nxt_send)
            ST_SEND_LEN: nxt_byte = len_q;
            ST_SEND_PAY: nxt_byte = pay_rd;
            default:     nxt_byte = crc;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sent_d    = sent_q;
        count_d   = count_q;
        len_d     = len_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            count_d = 8'd0;
            idx_d   = 8'd0;
            crc_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_d     = count_q;
                        idx_d     = 8'd0;
                        gap_cnt_d = 16'd0;
                        crc_clr   = 1'b1;
                        err_d     = wr_en;
                        state_d   = ST_SEND_HDR;
                        sent_d    = ST_SEND_HDR;
                        tx_wr_d   = 1'b1;
                        tx_data_d = HEADER;
                    end else if (wr_en) begin
                        if (count_q == MaxCnt) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + 8'd1;
                        end
                    end
                end
                ST_SEND_HDR, ST_SEND_LEN, ST_SEND_CRC: state_d = ST_WAIT_TX;
                ST_SEND_PAY: begin
                    state_d = ST_WAIT_TX;
                    crc_en  = 1'b1;
                    idx_d   = idx_q + 8'd1;
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        if (sent_q == ST_SEND_CRC) begin
                            done_d  = 1'b1;
                            count_d = 8'd0;
                            state_d = ST_IDLE;
                        end else if (GAP_CYCLES > 0) begin
                            gap_cnt_d = 16'd0;
                            state_d   = ST_GAP;
                        end else begin
                            state_d   = nxt_send;
                            sent_d    = nxt_send;
                            tx_wr_d   = 1'b1;
                            tx_data_d = nxt_byte;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GapLast) begin
                        state_d   = nxt_send;
                        sent_d    = nxt_send;
                        tx_wr_d   = 1'b1;
                        tx_data_d = nxt_byte;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_q != ST_IDLE && (start || wr_en)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sent_q    <= ST_IDLE;
            count_q   <= 8'd0;
            len_q     <= 8'd0;
            idx_q     <= 8'd0;
            gap_cnt_q <= 16'd0;
            tx_data_q <= 8'd0;
            tx_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sent_q    <= sent_d;
            count_q   <= count_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Payload storage needs no reset; count_q defines which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pay_mem_q[count_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign wr_full = (count_q == MaxCnt);
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign count   = count_q;
    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;

endmodule

// File: tb/tb_s3g_packet_sender.sv
// Randomized self-checking bench: two sender instances (small/no-gap and large/gap)
// driven against a UART responder and a queue-level frame reference model.
module tb_s3g_packet_sender;

    localparam int ND = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data [ND];
    logic       wr_en   [ND];
    logic       start   [ND];
    logic       abort   [ND];
    logic       tx_done [ND];
    logic       wr_full [ND];
    logic       busy    [ND];
    logic       done    [ND];
    logic       err     [ND];
    logic [7:0] count   [ND];
    logic [7:0] tx_data [ND];
    logic       tx_wr   [ND];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_mem [ND][512];
    int         rx_n       [ND];
    int         done_n     [ND];
    int         cnt_down   [ND];
    int         uart_delay [ND];
    int         last_done  [ND];

    logic [7:0] ref_buf [ND][256];
    int         ref_cnt [ND];
    logic       ref_err [ND];

    function automatic int maxp(input int d);
        return (d == 0) ? 4 : 64;
    endfunction

    function automatic int gapc(input int d);
        return (d == 0) ? 0 : 5;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_dut
        s3g_packet_sender #(
            .MAX_PAYLOAD ((g == 0) ? 4 : 64),
            .ADDR_W      ((g == 0) ? 2 : 6),
            .HEADER      (8'hD5),
            .GAP_CYCLES  ((g == 0) ? 0 : 5)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_data (wr_data[g]),
            .wr_en   (wr_en[g]),
            .wr_full (wr_full[g]),
            .start   (start[g]),
            .abort   (abort[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .err     (err[g]),
            .count   (count[g]),
            .tx_data (tx_data[g]),
            .tx_wr   (tx_wr[g]),
            .tx_done (tx_done[g])
        );

        // UART responder: captures each tx_wr byte, answers tx_done after uart_delay cycles.
        always @(posedge clk) begin
            #1;
            tx_done[g] = 1'b0;
            if (tx_wr[g]) begin
                if (last_done[g] >= 0) check_eq("gap_spacing", cyc - last_done[g], gapc(g) + 1);
                last_done[g] = -1;
                if (rx_n[g] < 512) rx_mem[g][rx_n[g]] = tx_data[g];
                rx_n[g]++;
                cnt_down[g] = uart_delay[g];
            end else if (cnt_down[g] > 0) begin
                cnt_down[g]--;
                if (cnt_down[g] == 0) begin
                    tx_done[g] = 1'b1;
                    last_done[g] = cyc;
                end
            end
            if (done[g]) done_n[g]++;
        end
    end

    // Reference CRC8 computed bit-serially, LSB first.
    function automatic logic [7:0] crc8_ref(input int d, input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                logic mix;
                mix = c[0] ^ ref_buf[d][i][b];
                c = c >> 1;
                if (mix) c = c ^ 8'h8C;
            end
        end
        return c;
    endfunction

    task automatic push(input int d, input logic [7:0] b);
        wr_data[d] = b;
        wr_en[d] = 1'b1;
        @(negedge clk);
        wr_en[d] = 1'b0;
        if (ref_cnt[d] < maxp(d)) begin
            ref_buf[d][ref_cnt[d]] = b;
            ref_cnt[d]++;
        end else begin
            ref_err[d] = 1'b1;
        end
        check_eq("load_count", count[d], ref_cnt[d]);
        check_eq("load_full", wr_full[d], (ref_cnt[d] == maxp(d)) ? 1 : 0);
        check_eq("load_err", err[d], ref_err[d]);
    endtask

    // poke: 0 none, 1 start while busy, 2 wr_en while busy.
    task automatic send_frame(input int d, input int delay, input int poke);
        logic [7:0] exp_b[$];
        int n, budget, t, poke_at;
        n = ref_cnt[d];
        exp_b.push_back(8'hD5);
        exp_b.push_back(8'(n));
        for (int i = 0; i < n; i++) exp_b.push_back(ref_buf[d][i]);
        exp_b.push_back(crc8_ref(d, n));
        rx_n[d] = 0;
        done_n[d] = 0;
        last_done[d] = -1;
        uart_delay[d] = delay;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        ref_err[d] = 1'b0;
        check_eq("hdr_tx_wr", tx_wr[d], 1);
        check_eq("hdr_tx_data", tx_data[d], 8'hD5);
        check_eq("busy_sending", busy[d], 1);
        budget = exp_b.size() * (delay + gapc(d) + 4) + 50;
        poke_at = (poke != 0) ? int'($urandom_range(1, 4)) : -1;
        t = 0;
        while (done_n[d] == 0 && t < budget) begin
            if (t == poke_at && busy[d]) begin
                if (poke == 1) start[d] = 1'b1;
                else begin
                    wr_en[d] = 1'b1;
                    wr_data[d] = 8'($urandom);
                end
                ref_err[d] = 1'b1;
            end
            @(negedge clk);
            start[d] = 1'b0;
            wr_en[d] = 1'b0;
            t++;
        end
        repeat (5) @(negedge clk);
        ref_cnt[d] = 0;
        check_eq("done_pulses", done_n[d], 1);
        check_eq("frame_len", rx_n[d], exp_b.size());
        for (int i = 0; i < exp_b.size() && i < rx_n[d]; i++) begin
            check_eq($sformatf("byte%0d", i), rx_mem[d][i], exp_b[i]);
        end
        check_eq("count_after", count[d], 0);
        check_eq("busy_after", busy[d], 0);
        check_eq("err_after", err[d], ref_err[d]);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            wr_data[d] = 8'h00; wr_en[d] = 1'b0; start[d] = 1'b0; abort[d] = 1'b0;
            rx_n[d] = 0; done_n[d] = 0; cnt_down[d] = 0; uart_delay[d] = 1;
            last_done[d] = -1; ref_cnt[d] = 0; ref_err[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check_eq("rst_busy", busy[d], 0);
            check_eq("rst_count", count[d], 0);
            check_eq("rst_err", err[d], 0);
            check_eq("rst_done", done[d], 0);
            check_eq("rst_tx_wr", tx_wr[d], 0);
            check_eq("rst_tx_data", tx_data[d], 0);
            check_eq("rst_full", wr_full[d], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Three-byte frame through the gapped instance, slow UART.
        push(1, 8'h76); push(1, 8'h54); push(1, 8'h81);
        send_frame(1, 100, 0);

        // Single byte, known CRC.
        push(0, 8'h01);
        send_frame(0, 3, 0);
        check_eq("crc_01", rx_mem[0][3], 8'h5E);

        // Empty payload.
        send_frame(0, 2, 0);
        check_eq("empty_crc", rx_mem[0][2], 8'h00);

        // Overfill the 4-deep instance.
        for (int i = 0; i < 5; i++) push(0, 8'(8'hA0 + i));
        send_frame(0, 4, 0);

        // Abort in IDLE discards the buffer.
        push(0, 8'h11); push(0, 8'h22);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        ref_cnt[0] = 0;
        check_eq("idle_abort_count", count[0], 0);

        // Abort while awaiting the second payload byte's tx_done.
        for (int i = 0; i < 4; i++) push(1, 8'(8'h30 + i));
        rx_n[1] = 0; done_n[1] = 0; last_done[1] = -1; uart_delay[1] = 20;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        ref_err[1] = 1'b0;
        t = 0;
        while (rx_n[1] < 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("abort_reach", rx_n[1], 4);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        ref_cnt[1] = 0;
        check_eq("abort_busy", busy[1], 0);
        check_eq("abort_count", count[1], 0);
        check_eq("abort_tx_wr", tx_wr[1], 0);
        repeat (60) @(negedge clk);
        check_eq("abort_no_more_tx", rx_n[1], 4);
        check_eq("abort_no_done", done_n[1], 0);
        check_eq("abort_busy_late", busy[1], 0);
        check_eq("abort_err", err[1], ref_err[1]);
        push(1, 8'h01);
        send_frame(1, 2, 0);

        // Randomized frames with occasional illegal start/write while busy.
        for (int k = 0; k < 16; k++) begin
            int d, n;
            d = int'($urandom_range(0, 1));
            n = int'($urandom_range(0, (d == 0) ? 5 : 10));
            for (int i = 0; i < n; i++) push(d, 8'($urandom));
            send_frame(d, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
